// File: rtl/sdram_ar.sv
// -----------------------------------------------------------------------------
// sdram_ar -- SDRAM auto-refresh command sequencer
//
// Runs one refresh sequence per accepted request:
//   [PRECHARGE ALL, tRP NOPs]  (only when SDRAM_AR_PRECHARGE_EN is defined)
//   AR_NUM x (AUTO REFRESH, tRFC NOPs)
//   one-cycle ar_end pulse
// Every command is held for exactly one clock; NOP is driven on all other
// cycles.
//
// Optional feature macro: SDRAM_AR_PRECHARGE_EN
//   defined   -> each sequence starts with PRECHARGE ALL followed by tRP wait
//   undefined -> the precharge states are compiled out and IDLE goes directly
//                to AUTO REFRESH
//
// Parameters
//   TRP_CLK   NOP cycles after PRECHARGE ALL (1..15)
//   TRFC_CLK  NOP cycles after each AUTO REFRESH (1..15)
//   AR_NUM    AUTO REFRESH commands per sequence (1..7)
//
// Ports
//   sys_clk    in   single clock, rising edge
//   sys_rst_n  in   synchronous reset, active HIGH despite the name
//   init_done  in   SDRAM power-up init complete; requests ignored while low
//   ar_en      in   level request from the arbiter
//   ar_end     out  one-cycle pulse when a sequence completes
//   ar_cmdo    out  {CS_n, RAS_n, CAS_n, WE_n}
//   ar_bao     out  bank address, fixed 2'b11
//   ar_addro   out  address bus, fixed 12'hFFF (A10=1: precharge all banks)
// All outputs are registered.
// -----------------------------------------------------------------------------
module sdram_ar #(
  parameter int TRP_CLK  = 2,
  parameter int TRFC_CLK = 7,
  parameter int AR_NUM   = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        init_done,
  input  logic        ar_en,
  output logic        ar_end,
  output logic [3:0]  ar_cmdo,
  output logic [1:0]  ar_bao,
  output logic [11:0] ar_addro
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PCHG = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  // The wait counter holds at the longest wait so it can never wrap.
  localparam logic [3:0] WAIT_MAX  = 4'((TRP_CLK > TRFC_CLK) ? TRP_CLK : TRFC_CLK);
  localparam logic [3:0] TRFC_LAST = 4'(TRFC_CLK - 1);
  localparam logic [2:0] AR_LAST   = 3'(AR_NUM);
`ifdef SDRAM_AR_PRECHARGE_EN
  localparam logic [3:0] TRP_LAST  = 4'(TRP_CLK - 1);
`endif

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
`ifdef SDRAM_AR_PRECHARGE_EN
    PCHG      = 3'd1,
    TRP_WAIT  = 3'd2,
`endif
    AREF      = 3'd3,
    TRFC_WAIT = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt;
  logic [2:0] ref_cnt;
  logic       in_wait;
  logic [3:0] cmd_nxt;
  logic       end_nxt;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v >= WAIT_MAX) ? v : v + 4'd1;
  endfunction

  // Next-state and command decode; the command for the current state is
  // registered, so it appears on the edge that leaves that state.
  always_comb begin
    state_nxt = state;
    cmd_nxt   = CMD_NOP;
    end_nxt   = 1'b0;
    in_wait   = 1'b0;
    case (state)
      IDLE: begin
        if (ar_en && init_done) begin
`ifdef SDRAM_AR_PRECHARGE_EN
          state_nxt = PCHG;
`else
          state_nxt = AREF;
`endif
        end
      end
`ifdef SDRAM_AR_PRECHARGE_EN
      PCHG: begin
        cmd_nxt   = CMD_PCHG;
        state_nxt = TRP_WAIT;
      end
      TRP_WAIT: begin
        in_wait = 1'b1;
        if (wait_cnt == TRP_LAST) state_nxt = AREF;
      end
`endif
      AREF: begin
        cmd_nxt   = CMD_AREF;
        state_nxt = TRFC_WAIT;
      end
      TRFC_WAIT: begin
        in_wait = 1'b1;
        if (wait_cnt == TRFC_LAST)
          state_nxt = (ref_cnt == AR_LAST) ? DONE : AREF;
      end
      DONE: begin
        end_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge sys_clk) begin
    ar_bao   <= 2'b11;
    ar_addro <= 12'hFFF;
    if (sys_rst_n) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      ref_cnt  <= 3'd0;
      ar_cmdo  <= CMD_NOP;
      ar_end   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ar_cmdo <= cmd_nxt;
      ar_end  <= end_nxt;
      // Zero on every state change so each wait state starts from 0.
      if (!in_wait || state_nxt != state) wait_cnt <= 4'd0;
      else                                 wait_cnt <= sat_inc(wait_cnt);
      if (state == IDLE)      ref_cnt <= 3'd0;
      else if (state == AREF) ref_cnt <= ref_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_sdram_ar.sv
module tb_sdram_ar;

  localparam int TRP  = 2;
  localparam int TRFC = 7;
  localparam int ARN  = 2;
`ifdef SDRAM_AR_PRECHARGE_EN
  localparam int PRE = 1 + TRP;
`else
  localparam int PRE = 0;
`endif
  // Edge index (after E0) of the ar_end pulse.
  localparam int LAST = PRE + ARN * (TRFC + 1) + 1;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PCH  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        init_done = 1'b0;
  logic        ar_en = 1'b0;
  logic        ar_end;
  logic [3:0]  ar_cmdo;
  logic [1:0]  ar_bao;
  logic [11:0] ar_addro;

  sdram_ar #(.TRP_CLK(TRP), .TRFC_CLK(TRFC), .AR_NUM(ARN)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .init_done(init_done),
    .ar_en    (ar_en),
    .ar_end   (ar_end),
    .ar_cmdo  (ar_cmdo),
    .ar_bao   (ar_bao),
    .ar_addro (ar_addro)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a busy flag and the edge index since acceptance.
  bit         busy = 0;
  int         k = 0;
  logic [3:0] exp_cmd = NOP;
  logic       exp_end = 1'b0;

  // Expected command on edge n after acceptance, from the sequence rules.
  function automatic logic [3:0] cmd_at(input int n);
    if (PRE != 0 && n == 1) return PCH;
    for (int r = 0; r < ARN; r++)
      if (n == PRE + 1 + r * (TRFC + 1)) return AREF;
    return NOP;
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance model on the edge, compare just after.
  task automatic step(input logic rst, input logic en, input logic init);
    sys_rst_n = rst;
    ar_en     = en;
    init_done = init;
    @(posedge sys_clk);
    if (rst) begin
      busy = 0; k = 0; exp_cmd = NOP; exp_end = 1'b0;
    end else if (busy) begin
      k++;
      exp_cmd = cmd_at(k);
      exp_end = (k == LAST);
      if (k == LAST) busy = 0;
    end else begin
      exp_cmd = NOP;
      exp_end = 1'b0;
      if (en && init) begin busy = 1; k = 0; end
    end
    #1;
    chk("cmd",  12'(ar_cmdo), 12'(exp_cmd));
    chk("end",  12'(ar_end),  12'(exp_end));
    chk("ba",   12'(ar_bao),  12'h003);
    chk("addr", ar_addro,     12'hFFF);
    @(negedge sys_clk);
  endtask

  int end_edge, first_edge, pulses;
  logic [3:0] first_cmd;
  bit en_hold;

  initial begin
    // Reset held 3 cycles with the request active
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);

    // One full sequence, arbiter drops ar_en after seeing ar_end
    end_edge = -1; first_edge = -1; first_cmd = NOP; pulses = 0; en_hold = 1;
    step(1'b0, 1'b1, 1'b1);                    // E0
    for (int n = 1; n <= LAST + 6; n++) begin
      step(1'b0, en_hold, 1'b1);
      if (ar_cmdo !== NOP && first_edge < 0) begin first_edge = n; first_cmd = ar_cmdo; end
      if (ar_end === 1'b1) begin pulses++; end_edge = n; en_hold = 0; end
    end
    chk("seq_end_edge",  12'(end_edge),   12'(LAST));
    chk("seq_pulses",    12'(pulses),     12'd1);
    chk("seq_first_edge", 12'(first_edge), 12'd1);
    chk("seq_first_cmd", 12'(first_cmd),  12'((PRE != 0) ? PCH : AREF));

    // Requests ignored while init_done is low
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (ar_end === 1'b1 || ar_cmdo !== NOP) pulses++;
    end
    chk("noinit_activity", 12'(pulses), 12'd0);

    // Reset at E6 aborts the sequence with no ar_end
    step(1'b0, 1'b1, 1'b1);                    // E0
    for (int n = 1; n <= 5; n++) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b1, 1'b1, 1'b1);                    // E6
    pulses = 0;
    for (int i = 0; i < LAST + 5; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (ar_end === 1'b1 || ar_cmdo !== NOP) pulses++;
    end
    chk("abort_activity", 12'(pulses), 12'd0);

    // ar_en held high through ar_end: back-to-back sequences
    end_edge = -1; pulses = 0; first_edge = -1;
    step(1'b0, 1'b1, 1'b1);                    // E0
    for (int n = 1; n <= 2 * LAST + 4; n++) begin
      step(1'b0, n <= LAST + 1, 1'b1);
      if (ar_end === 1'b1) begin pulses++; end_edge = n; end
      if (n > LAST + 1 && ar_cmdo !== NOP && first_edge < 0) first_edge = n;
    end
    chk("b2b_pulses",     12'(pulses),     12'd2);
    chk("b2b_end_edge",   12'(end_edge),   12'(2 * LAST + 1));
    chk("b2b_first_edge", 12'(first_edge), 12'(LAST + 2));

    // Randomized traffic: request/init toggling, occasional reset
    for (int i = 0; i < 800; i++)
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) != 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_ar.md
SDRAM_AR -- requirements
Module: sdram_ar

Interface
REQ-001 Parameter TRP_CLK, default 2: NOP cycles after PRECHARGE ALL (tRP); legal range 1..15.
REQ-002 Parameter TRFC_CLK, default 7: NOP cycles after each AUTO REFRESH (tRFC); legal range 1..15.
REQ-003 Parameter AR_NUM, default 2: AUTO REFRESH commands per sequence; legal range 1..7.
REQ-004 Port sys_clk, input, 1 bit: single clock; all logic SHALL be on its rising edge.
REQ-005 Port sys_rst_n, input, 1 bit: synchronous, active-high reset.
REQ-006 Port init_done, input, 1 bit: SDRAM power-up initialization complete; refresh sequences are permitted only while it is high.
REQ-007 Port ar_en, input, 1 bit: level request from the arbiter to run one refresh sequence.
REQ-008 Port ar_end, output, 1 bit: one-cycle pulse marking sequence completion.
REQ-009 Port ar_cmdo, output, 4 bits: {CS_n, RAS_n, CAS_n, WE_n}.
REQ-010 Port ar_bao, output, 2 bits: bank address.
REQ-011 Port ar_addro, output, 12 bits: address bus.

Function
REQ-012 Command encodings SHALL be NOP=4'b0111, PRECHARGE=4'b0010, AUTO_REFRESH=4'b0001.
REQ-013 ar_bao SHALL be constant 2'b11 and ar_addro constant 12'hFFF (A10=1 selects all banks for PRECHARGE).
REQ-014 All outputs SHALL be registered, and each command SHALL be driven for exactly one clock, with NOP on every other cycle.
REQ-015 FSM states: IDLE, PCHG, TRP_WAIT, AREF, TRFC_WAIT, DONE.
REQ-016 In IDLE, ar_cmdo SHALL be NOP and ar_end 0; the FSM SHALL leave IDLE only when ar_en=1 and init_done=1 are sampled on the same edge (edge E0).
REQ-017 While init_done=0, ar_en SHALL be ignored.
REQ-018 With the defaults and the macro defined, the sequence SHALL be:
  - E1: PRECHARGE.
  - E2-E3: NOP.
  - E4: AUTO_REFRESH.
  - E5-E11: NOP.
  - E12: AUTO_REFRESH.
  - E13-E19: NOP.
  - E20: ar_end=1 with NOP.
  - E21: IDLE with ar_end=0.
REQ-019 In general, the sequence SHALL be: PCHG 1 cycle, then TRP_WAIT TRP_CLK cycles, then AR_NUM repetitions of (AREF 1 cycle, TRFC_WAIT TRFC_CLK cycles), then DONE 1 cycle.
REQ-020 The refresh counter SHALL count AUTO_REFRESH commands, and the transition to DONE SHALL occur when the count reaches AR_NUM after the final TRFC_WAIT.
REQ-021 ar_en changes during a sequence SHALL be ignored; a started sequence always completes, even if init_done falls.
REQ-022 The arbiter SHALL deassert ar_en upon seeing ar_end; if ar_en is still high when the FSM is in IDLE, a new sequence SHALL start (no minimum gap is enforced).
REQ-023 Wait counters SHALL reset to 0 on entry to each wait state and SHALL be wide enough for 15 without wrap.

Reset
REQ-024 With sys_rst_n=1 at an edge, on that edge the FSM SHALL go to IDLE, ar_cmdo SHALL become NOP, ar_end 0, ar_bao 2'b11 and ar_addro 12'hFFF, and all counters SHALL clear.
REQ-025 A reset asserted mid-sequence SHALL abort it with no ar_end pulse; after reset release a new ar_en is required.

Configuration
REQ-026 Macro SDRAM_AR_PRECHARGE_EN defined: each sequence SHALL begin with PCHG and TRP_WAIT per REQ-018.
REQ-027 Macro SDRAM_AR_PRECHARGE_EN undefined: PCHG and TRP_WAIT SHALL be compiled out, with IDLE going directly to AREF.
  - Defaults then give AUTO_REFRESH at E1 and E9, NOP elsewhere, ar_end at E17.

Verification
REQ-028 Reset held 3 cycles -> ar_cmdo=4'b0111, ar_end=0, ar_bao=2'b11, ar_addro=12'hFFF throughout.
REQ-029 init_done=1, ar_en=1 held until ar_end (macro on) -> PRECHARGE at E1, AUTO_REFRESH at E4 and E12, single ar_end pulse at E20, all other cycles NOP.
REQ-030 init_done=0, ar_en=1 for 50 cycles -> ar_cmdo stays NOP and ar_end never asserts.
REQ-031 Reset asserted at E6 of a sequence -> NOP from E6 onward, no ar_end, FSM in IDLE.
REQ-032 ar_en held high after ar_end -> second sequence, with PRECHARGE one cycle after the IDLE edge on which ar_en is sampled.
REQ-033 Macro off -> AUTO_REFRESH at E1 and E9, ar_end at E17.
